tag_array_lookup: RTL and testbench

// - Parametrised successor to the per-way tag store. Holds {valid, dirty, tag} per way and set, one mpc_sram per way.
// - Clears itself after reset and on flush request with a hardware sweep.
// - Registered read path also does the tag compare, returning a hit vector and an encoded hit way.
// - Sits between the HTU lookup pipeline and the cache refill/evict logic.

---
 rtl/tag_array_lookup_pkg.sv | 23 ++
 rtl/tag_array_lookup_if.sv | 55 +++++
 rtl/mpc_sram.sv | 32 +++
 rtl/tag_hit_encode.sv | 35 +++
 rtl/tag_array_lookup.sv | 176 +++++++++++++++++
 tb/tb_tag_array_lookup.sv | 225 ++++++++++++++++++++++
 6 files changed

// File: rtl/tag_array_lookup_pkg.sv
// Shared types for the per-way tag store.
// Holds the FSM encoding, the default-width entry layout and a way-index width helper.
package tag_array_lookup_pkg;

  typedef enum logic {
    TAG_INIT = 1'b0,
    TAG_IDLE = 1'b1
  } tag_fsm_e;

  localparam int MPC_TAG_W = 20;

  // Entry layout, MSB first; the top-level uses the same layout at its own TAG_W.
  typedef struct packed {
    logic                 vld;
    logic                 dirty;
    logic [MPC_TAG_W-1:0] tag;
  } mpc_tag_entry_t;

  function automatic int calc_way_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/tag_array_lookup_if.sv
// Lookup, write, flush and response bundle of the tag store.
// master = requester (lookup pipeline / refill logic), slave = tag_array_lookup.
interface tag_array_lookup_if #(
  parameter int WAYS  = 4,
  parameter int SETS  = 64,
  parameter int TAG_W = 20
);
  import tag_array_lookup_pkg::*;

  localparam int SET_W = $clog2(SETS);
  localparam int WAY_W = calc_way_w(WAYS);

  logic                  init_done;
  logic                  flush_req;
  logic                  flush_ack;

  logic                  rd_valid;
  logic                  rd_ready;
  logic [SET_W-1:0]      rd_set;
  logic [TAG_W-1:0]      rd_tag;

  logic                  rsp_valid;
  logic [WAYS*TAG_W-1:0] rsp_tag;
  logic [WAYS-1:0]       rsp_vld_vec;
  logic [WAYS-1:0]       rsp_dirty_vec;
  logic [WAYS-1:0]       rsp_hit_vec;
  logic                  rsp_hit;
  logic [WAY_W-1:0]      rsp_hit_way;
  logic                  rsp_multi_hit;

  logic                  wr_valid;
  logic                  wr_ready;
  logic [SET_W-1:0]      wr_set;
  logic [WAYS-1:0]       wr_way_en;
  logic [TAG_W-1:0]      wr_tag;
  logic                  wr_vld;
  logic                  wr_dirty;

  modport master (
    input  init_done, flush_ack, rd_ready, wr_ready,
           rsp_valid, rsp_tag, rsp_vld_vec, rsp_dirty_vec,
           rsp_hit_vec, rsp_hit, rsp_hit_way, rsp_multi_hit,
    output flush_req, rd_valid, rd_set, rd_tag,
           wr_valid, wr_set, wr_way_en, wr_tag, wr_vld, wr_dirty
  );

  modport slave (
    output init_done, flush_ack, rd_ready, wr_ready,
           rsp_valid, rsp_tag, rsp_vld_vec, rsp_dirty_vec,
           rsp_hit_vec, rsp_hit, rsp_hit_way, rsp_multi_hit,
    input  flush_req, rd_valid, rd_set, rd_tag,
           wr_valid, wr_set, wr_way_en, wr_tag, wr_vld, wr_dirty
  );

endinterface

// File: rtl/mpc_sram.sv
// Single-port synchronous SRAM: one read or write per cycle, read data 1 cycle later.
// rdata only changes on a read, so a later write never disturbs a result already presented.
module mpc_sram #(
  parameter int DATA_SIZE = 22,
  parameter int ADDR_SIZE = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cs,
  input  logic                 we,
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic [DATA_SIZE-1:0] wdata,
  output logic [DATA_SIZE-1:0] rdata
);

  logic [DATA_SIZE-1:0] mem [0:(1<<ADDR_SIZE)-1];

  always_ff @(posedge clk) begin
    if (cs && we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (cs && !we) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/tag_hit_encode.sv
// Reduces a per-way hit vector to hit, lowest-index hit way and a multi-hit error flag.
// Purely combinational.
module tag_hit_encode
  import tag_array_lookup_pkg::*;
#(
  parameter int WAYS = 4
) (
  input  logic [WAYS-1:0]             hit_vec,
  output logic                        hit,
  output logic [calc_way_w(WAYS)-1:0] hit_way,
  output logic                        multi_hit
);

  localparam int WAY_W = calc_way_w(WAYS);

  logic seen;

  always_comb begin
    hit_way   = '0;
    multi_hit = 1'b0;
    seen      = 1'b0;
    hit       = |hit_vec;
    for (int w = 0; w < WAYS; w++) begin
      if (hit_vec[w]) begin
        if (seen) begin
          multi_hit = 1'b1;
        end else begin
          hit_way = WAY_W'(w);
          seen    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/tag_array_lookup.sv
// Per-way {vld, dirty, tag} store with a clearing sweep after reset/flush and a 1-cycle lookup+compare.
// Writes beat reads in the same cycle; nothing is accepted during a sweep or while flush_req is high.
module tag_array_lookup
  import tag_array_lookup_pkg::*;
#(
  parameter int WAYS  = 4,
  parameter int SETS  = 64,
  parameter int TAG_W = 20
) (
  input  logic               clk,
  input  logic               rst,
  tag_array_lookup_if.slave  bus
);

  localparam int SET_W = $clog2(SETS);
  localparam int WAY_W = calc_way_w(WAYS);
  localparam int ENT_W = TAG_W + 2;

  typedef struct packed {
    logic             vld;
    logic             dirty;
    logic [TAG_W-1:0] tag;
  } entry_t;

  tag_fsm_e         state, state_nxt;
  logic [SET_W-1:0] init_cnt, init_cnt_nxt;
  logic             flush_sweep, flush_sweep_nxt;
  logic             flush_ack_q, flush_ack_nxt;
  logic             rsp_valid_q;
  logic [TAG_W-1:0] rd_tag_q;

  logic             in_init, init_done_c, rd_ready_c, wr_ready_c;
  logic             rd_accept, wr_accept;

  logic [WAYS-1:0]  sram_cs, sram_we;
  logic [SET_W-1:0] sram_addr;
  entry_t           sram_wdata;
  logic [ENT_W-1:0] sram_rdata [WAYS];
  logic             rst_n;

  logic [WAYS*TAG_W-1:0] rsp_tag_c;
  logic [WAYS-1:0]       vld_vec_c, dirty_vec_c, hit_raw, hit_vec;
  logic                  hit_c, multi_hit_c;
  logic [WAY_W-1:0]      hit_way_c;
  entry_t                ent;

  assign rst_n     = ~rst;
  assign rd_accept = bus.rd_valid & rd_ready_c;
  assign wr_accept = bus.wr_valid & wr_ready_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= TAG_INIT;
      init_cnt    <= '0;
      flush_sweep <= 1'b0;
      flush_ack_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rd_tag_q    <= '0;
    end else begin
      state       <= state_nxt;
      init_cnt    <= init_cnt_nxt;
      flush_sweep <= flush_sweep_nxt;
      flush_ack_q <= flush_ack_nxt;
      rsp_valid_q <= rd_accept;
      if (rd_accept) begin
        rd_tag_q <= bus.rd_tag;
      end
    end
  end

  always_comb begin
    state_nxt       = state;
    init_cnt_nxt    = init_cnt;
    flush_sweep_nxt = flush_sweep;
    flush_ack_nxt   = 1'b0;
    in_init         = 1'b0;
    init_done_c     = 1'b0;
    rd_ready_c      = 1'b0;
    wr_ready_c      = 1'b0;
    case (state)
      TAG_INIT: begin
        in_init      = 1'b1;
        init_cnt_nxt = init_cnt + 1'b1;
        if (init_cnt == SET_W'(SETS - 1)) begin
          state_nxt       = TAG_IDLE;
          init_cnt_nxt    = '0;
          // Only a flush-initiated sweep acknowledges; the post-reset sweep stays silent.
          flush_ack_nxt   = flush_sweep;
          flush_sweep_nxt = 1'b0;
        end
      end
      TAG_IDLE: begin
        init_done_c = 1'b1;
        wr_ready_c  = !bus.flush_req;
        rd_ready_c  = !bus.flush_req && !bus.wr_valid;
        if (bus.flush_req) begin
          state_nxt       = TAG_INIT;
          init_cnt_nxt    = '0;
          flush_sweep_nxt = 1'b1;
        end
      end
      default: state_nxt = TAG_INIT;
    endcase
  end

  always_comb begin
    sram_cs = '0;
    sram_we = '0;
    for (int w = 0; w < WAYS; w++) begin
      sram_we[w] = (wr_accept & bus.wr_way_en[w]) | in_init;
      sram_cs[w] = sram_we[w] | rd_accept;
    end
    sram_addr = in_init ? init_cnt : ((|sram_we) ? bus.wr_set : bus.rd_set);
    sram_wdata = '0;
    if (!in_init) begin
      sram_wdata.vld   = bus.wr_vld;
      sram_wdata.dirty = bus.wr_dirty;
      sram_wdata.tag   = bus.wr_tag;
    end
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    mpc_sram #(
      .DATA_SIZE(ENT_W),
      .ADDR_SIZE(SET_W)
    ) u_sram (
      .clk   (clk),
      .rst_n (rst_n),
      .cs    (sram_cs[w]),
      .we    (sram_we[w]),
      .addr  (sram_addr),
      .wdata (sram_wdata),
      .rdata (sram_rdata[w])
    );
  end

  // Compare runs on the SRAM output against the tag captured with the accepted read.
  always_comb begin
    ent         = '0;
    rsp_tag_c   = '0;
    vld_vec_c   = '0;
    dirty_vec_c = '0;
    hit_raw     = '0;
    for (int w = 0; w < WAYS; w++) begin
      ent                           = entry_t'(sram_rdata[w]);
      rsp_tag_c[w*TAG_W +: TAG_W]   = ent.tag;
      vld_vec_c[w]                  = ent.vld;
      dirty_vec_c[w]                = ent.dirty;
      hit_raw[w]                    = ent.vld && (ent.tag == rd_tag_q);
    end
    hit_vec = rsp_valid_q ? hit_raw : '0;
  end

  tag_hit_encode #(
    .WAYS(WAYS)
  ) u_hit_encode (
    .hit_vec   (hit_vec),
    .hit       (hit_c),
    .hit_way   (hit_way_c),
    .multi_hit (multi_hit_c)
  );

  assign bus.init_done     = init_done_c;
  assign bus.flush_ack     = flush_ack_q;
  assign bus.rd_ready      = rd_ready_c;
  assign bus.wr_ready      = wr_ready_c;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_tag       = rsp_tag_c;
  assign bus.rsp_vld_vec   = vld_vec_c;
  assign bus.rsp_dirty_vec = dirty_vec_c;
  assign bus.rsp_hit_vec   = hit_vec;
  assign bus.rsp_hit       = hit_c;
  assign bus.rsp_hit_way   = hit_way_c;
  assign bus.rsp_multi_hit = multi_hit_c;

endmodule

// File: tb/tb_tag_array_lookup.sv
// Directed bench for tag_array_lookup: init sweep, hits, write/read priority, multi-hit, flush, reset mid-sweep.
module tb_tag_array_lookup;

  localparam int WAYS  = 4;
  localparam int SETS  = 64;
  localparam int TAG_W = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  tag_array_lookup_if #(.WAYS(WAYS), .SETS(SETS), .TAG_W(TAG_W)) bus ();

  tag_array_lookup #(.WAYS(WAYS), .SETS(SETS), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.flush_req = 1'b0;
    bus.rd_valid  = 1'b0;
    bus.rd_set    = '0;
    bus.rd_tag    = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_set    = '0;
    bus.wr_way_en = '0;
    bus.wr_tag    = '0;
    bus.wr_vld    = 1'b0;
    bus.wr_dirty  = 1'b0;
  endtask

  task automatic do_write(input logic [5:0] set, input logic [3:0] en, input logic [19:0] tag,
                          input logic v, input logic d);
    bus.wr_valid  = 1'b1;
    bus.wr_set    = set;
    bus.wr_way_en = en;
    bus.wr_tag    = tag;
    bus.wr_vld    = v;
    bus.wr_dirty  = d;
    #1;
    check("wr_ready", 64'(bus.wr_ready), 64'd1);
    tick();
    bus.wr_valid = 1'b0;
  endtask

  task automatic do_read(input logic [5:0] set, input logic [19:0] tag);
    bus.rd_valid = 1'b1;
    bus.rd_set   = set;
    bus.rd_tag   = tag;
    #1;
    check("rd_ready", 64'(bus.rd_ready), 64'd1);
    tick();
    bus.rd_valid = 1'b0;
  endtask

  // Runs the 64 sweep cycles and counts any cycle where something that must stay low was high.
  task automatic sweep(input string name);
    int rdy_seen  = 0;
    int done_seen = 0;
    int ack_seen  = 0;
    int rspv_seen = 0;
    for (int i = 0; i < SETS; i++) begin
      if (bus.rd_ready || bus.wr_ready) rdy_seen++;
      if (bus.init_done) done_seen++;
      if (bus.flush_ack) ack_seen++;
      if (bus.rsp_valid) rspv_seen++;
      tick();
    end
    check({name, "_ready_during_sweep"}, 64'(rdy_seen), 64'd0);
    check({name, "_done_during_sweep"}, 64'(done_seen), 64'd0);
    check({name, "_ack_during_sweep"}, 64'(ack_seen), 64'd0);
    check({name, "_rspv_during_sweep"}, 64'(rspv_seen), 64'd0);
    check({name, "_init_done_after"}, 64'(bus.init_done), 64'd1);
  endtask

  initial begin
    idle_inputs();
    bus.rd_valid = 1'b1;
    bus.rd_set   = 6'd3;
    #22;
    check("rst_init_done", 64'(bus.init_done), 64'd0);
    check("rst_flush_ack", 64'(bus.flush_ack), 64'd0);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_rd_ready", 64'(bus.rd_ready), 64'd0);
    check("rst_wr_ready", 64'(bus.wr_ready), 64'd0);
    check("rst_hit_vec", 64'(bus.rsp_hit_vec), 64'd0);
    check("rst_rsp_tag", 64'(bus.rsp_tag[63:0]), 64'd0);

    @(negedge clk);
    rst = 1'b0;
    sweep("boot");
    check("boot_rd_ready", 64'(bus.rd_ready), 64'd1);
    check("boot_flush_ack", 64'(bus.flush_ack), 64'd0);
    tick();
    bus.rd_valid = 1'b0;
    check("clr_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    check("clr_vld_vec", 64'(bus.rsp_vld_vec), 64'd0);
    check("clr_hit", 64'(bus.rsp_hit), 64'd0);
    check("clr_hit_vec", 64'(bus.rsp_hit_vec), 64'd0);

    // Single-way hit with dirty set
    do_write(6'd5, 4'b0100, 20'hABCDE, 1'b1, 1'b1);
    do_read(6'd5, 20'hABCDE);
    check("s5_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    check("s5_hit_vec", 64'(bus.rsp_hit_vec), 64'h4);
    check("s5_hit_way", 64'(bus.rsp_hit_way), 64'd2);
    check("s5_dirty_vec", 64'(bus.rsp_dirty_vec), 64'h4);
    check("s5_vld_vec", 64'(bus.rsp_vld_vec), 64'h4);
    check("s5_hit", 64'(bus.rsp_hit), 64'd1);
    check("s5_multi", 64'(bus.rsp_multi_hit), 64'd0);
    check("s5_tag_w2", 64'(bus.rsp_tag[2*TAG_W +: TAG_W]), 64'hABCDE);
    tick();
    check("s5_rsp_valid_drop", 64'(bus.rsp_valid), 64'd0);
    check("s5_hit_vec_forced", 64'(bus.rsp_hit_vec), 64'd0);
    check("s5_hit_forced", 64'(bus.rsp_hit), 64'd0);

    // Write and read together: write wins, read follows and sees the new entry
    bus.wr_valid  = 1'b1;
    bus.wr_set    = 6'd12;
    bus.wr_way_en = 4'b0001;
    bus.wr_tag    = 20'h12345;
    bus.wr_vld    = 1'b1;
    bus.wr_dirty  = 1'b0;
    bus.rd_valid  = 1'b1;
    bus.rd_set    = 6'd12;
    bus.rd_tag    = 20'h12345;
    #1;
    check("pri_rd_ready", 64'(bus.rd_ready), 64'd0);
    check("pri_wr_ready", 64'(bus.wr_ready), 64'd1);
    tick();
    bus.wr_valid = 1'b0;
    #1;
    check("pri_no_rsp", 64'(bus.rsp_valid), 64'd0);
    check("pri_rd_ready2", 64'(bus.rd_ready), 64'd1);
    tick();
    bus.rd_valid = 1'b0;
    check("pri_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    check("pri_hit_vec", 64'(bus.rsp_hit_vec), 64'h1);
    check("pri_hit_way", 64'(bus.rsp_hit_way), 64'd0);
    check("pri_dirty_vec", 64'(bus.rsp_dirty_vec), 64'h0);

    // Two ways holding the same tag
    do_write(6'd9, 4'b1010, 20'h11, 1'b1, 1'b0);
    do_read(6'd9, 20'h11);
    check("mh_hit_vec", 64'(bus.rsp_hit_vec), 64'hA);
    check("mh_hit_way", 64'(bus.rsp_hit_way), 64'd1);
    check("mh_multi", 64'(bus.rsp_multi_hit), 64'd1);
    check("mh_hit", 64'(bus.rsp_hit), 64'd1);
    do_read(6'd9, 20'h12);
    check("miss_hit", 64'(bus.rsp_hit), 64'd0);
    check("miss_hit_vec", 64'(bus.rsp_hit_vec), 64'd0);
    check("miss_vld_vec", 64'(bus.rsp_vld_vec), 64'hA);
    check("miss_tag_w3", 64'(bus.rsp_tag[3*TAG_W +: TAG_W]), 64'h11);

    // Flush sweep
    bus.flush_req = 1'b1;
    bus.rd_valid  = 1'b1;
    bus.rd_set    = 6'd5;
    bus.rd_tag    = 20'hABCDE;
    #1;
    check("fl_rd_ready", 64'(bus.rd_ready), 64'd0);
    check("fl_wr_ready", 64'(bus.wr_ready), 64'd0);
    tick();
    bus.flush_req = 1'b0;
    sweep("flush");
    check("fl_ack", 64'(bus.flush_ack), 64'd1);
    tick();
    bus.rd_valid = 1'b0;
    check("fl_ack_pulse", 64'(bus.flush_ack), 64'd0);
    check("fl_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    check("fl_old_hit", 64'(bus.rsp_hit), 64'd0);
    check("fl_vld_vec", 64'(bus.rsp_vld_vec), 64'd0);

    // Reset in the middle of a flush sweep
    do_write(6'd5, 4'b0100, 20'hABCDE, 1'b1, 1'b0);
    bus.flush_req = 1'b1;
    tick();
    bus.flush_req = 1'b0;
    bus.rd_valid  = 1'b1;
    repeat (30) tick();
    rst = 1'b1;
    #1;
    check("mrst_init_done", 64'(bus.init_done), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    sweep("mrst");
    check("mrst_no_ack", 64'(bus.flush_ack), 64'd0);
    tick();
    check("mrst_no_ack2", 64'(bus.flush_ack), 64'd0);
    check("mrst_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    check("mrst_cleared", 64'(bus.rsp_vld_vec), 64'd0);

    // Reset with a lookup in flight
    tick();
    check("lrst_rsp_valid_pre", 64'(bus.rsp_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("lrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("lrst_hit_vec", 64'(bus.rsp_hit_vec), 64'd0);
    bus.rd_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
